// File: rtl/cpu_control_pkg.sv
// cpu_control_pkg
//   Shared definitions for the CPU control FSM and its helpers: opcode and
//   branch-condition encodings, the FSM state enum and the datapath select
//   enums (alu_output_override_t, pc_data_source_t, mem_write_addr_source_t,
//   mem_write_data_source_t). The first member of every select enum is the
//   value driven whenever the control FSM is idle or held in reset.
package cpu_control_pkg;

    // Register the datapath copies into PC when pc_data_source selects irq.
    localparam logic [3:0] IRQ_VECTOR_REG = 4'hC;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_ALU_RR = 4'h1;
    localparam logic [3:0] OP_ALU_RI = 4'h2;
    localparam logic [3:0] OP_LDI    = 4'h3;
    localparam logic [3:0] OP_LOAD   = 4'h4;
    localparam logic [3:0] OP_STORE  = 4'h5;
    localparam logic [3:0] OP_PUSH   = 4'h6;
    localparam logic [3:0] OP_POP    = 4'h7;
    localparam logic [3:0] OP_HALT   = 4'h8;
    localparam logic [3:0] OP_BR     = 4'h9;
    localparam logic [3:0] OP_CALL   = 4'hA;
    localparam logic [3:0] OP_RET    = 4'hB;
    localparam logic [3:0] OP_RTI    = 4'hC;

    localparam logic [3:0] COND_ALWAYS = 4'h0;
    localparam logic [3:0] COND_Z      = 4'h1;
    localparam logic [3:0] COND_NZ     = 4'h2;
    localparam logic [3:0] COND_N      = 4'h3;
    localparam logic [3:0] COND_NN     = 4'h4;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_EXEC,
        ST_LOAD_W,
        ST_POP_R,
        ST_HALT,
        ST_RET_R,
        ST_RTI_SR,
        ST_RTI_PC,
        ST_IRQ_PC,
        ST_IRQ_SR,
        ST_IRQ_JMP
    } state_t;

    typedef enum logic [0:0] {
        AOO_NONE,
        AOO_IMM8
    } alu_output_override_t;

    typedef enum logic [1:0] {
        PC_SRC_NEXT_PC,
        PC_SRC_REGISTER,
        PC_SRC_MEM,
        PC_SRC_IRQ
    } pc_data_source_t;

    typedef enum logic [0:0] {
        MWA_SP,
        MWA_REGISTER
    } mem_write_addr_source_t;

    typedef enum logic [1:0] {
        MWD_REGISTER,
        MWD_THIS_PC,
        MWD_SR
    } mem_write_data_source_t;

endpackage

// File: rtl/cpu_control_branch_eval.sv
// cpu_control_branch_eval
//   Combinational branch-condition evaluator.
//   Ports:
//     cond   in  4  condition field of the branch instruction
//     z_flag in  1  zero flag
//     n_flag in  1  negative flag
//     taken  out 1  branch is taken
//   Unassigned condition codes are never taken.
module cpu_control_branch_eval
    import cpu_control_pkg::*;
(
    input  logic [3:0] cond,
    input  logic       z_flag,
    input  logic       n_flag,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_ALWAYS: taken = 1'b1;
            COND_Z:      taken = z_flag;
            COND_NZ:     taken = ~z_flag;
            COND_N:      taken = n_flag;
            COND_NN:     taken = ~n_flag;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_control.sv
// cpu_control
//   Multi-cycle control FSM sequencing the CPU datapath: fetch, execute,
//   load/store, push/pop, call/return and interrupt entry/exit.
//   Ports:
//     clock, reset              system clock, synchronous active-low reset
//     current_instruction[15:0] latched instruction (opcode [15:12], cond [3:0])
//     Z_in, N_in                status flags from datapath
//     irq                       level interrupt request (sampled in FETCH only)
//     mem_rvalid                memory read data valid
//     reg_write .. reset_irq    single-bit datapath strobes
//     alu_output_override, pc_data_source,
//     mem_write_addr_source, mem_write_data_source   datapath selects
//     halted                    CPU stopped
//     in_isr                    interrupt service in progress (masks irq)
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   FETCH      | read instruction at PC, advance PC; take pending irq
//   EXEC       | decode/execute latched instruction
//   LOAD_W     | wait for load data, write it to register
//   POP_R      | SP already incremented; read stack into register
//   HALT       | stopped until reset
//   RET_R      | SP already incremented; read return address into PC
//   RTI_SR     | read saved status register, increment SP again
//   RTI_PC     | read saved PC, leave interrupt service
//   IRQ_PC     | push interrupted PC
//   IRQ_SR     | push status register
//   IRQ_JMP    | jump to vector, acknowledge irq
module cpu_control
    import cpu_control_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic [15:0]            current_instruction,
    input  logic                   Z_in,
    input  logic                   N_in,
    input  logic                   irq,
    input  logic                   mem_rvalid,
    output logic                   reg_write,
    output logic                   mem_to_reg,
    output logic                   mem_read_is_pc,
    output logic                   mem_read_is_sp,
    output logic                   alu_override_imm4,
    output logic                   alu_set_flags,
    output logic                   set_pc,
    output logic                   sr_from_mem,
    output logic                   mem_write,
    output logic                   set_sp,
    output logic                   increase_sp,
    output logic                   reset_irq,
    output alu_output_override_t   alu_output_override,
    output pc_data_source_t        pc_data_source,
    output mem_write_addr_source_t mem_write_addr_source,
    output mem_write_data_source_t mem_write_data_source,
    output logic                   halted,
    output logic                   in_isr
);

    state_t     state;
    state_t     next_state;
    logic       in_isr_q;
    logic [3:0] opcode;
    logic [3:0] cond;
    logic       br_taken;
    logic       unused_instr_bits;

    assign opcode            = current_instruction[15:12];
    assign cond              = current_instruction[3:0];
    assign unused_instr_bits = ^current_instruction[11:4];

    cpu_control_branch_eval u_branch_eval (
        .cond   (cond),
        .z_flag (Z_in),
        .n_flag (N_in),
        .taken  (br_taken)
    );

    // in_isr rises on entry to IRQ_JMP so the jump cycle already reports it,
    // and falls once the saved PC has been read back by RTI.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= ST_FETCH;
            in_isr_q <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_IRQ_SR) begin
                in_isr_q <= 1'b1;
            end else if (state == ST_RTI_PC && mem_rvalid) begin
                in_isr_q <= 1'b0;
            end
        end
    end

    assign in_isr = in_isr_q & reset;

    always_comb begin
        next_state            = state;
        reg_write             = 1'b0;
        mem_to_reg            = 1'b0;
        mem_read_is_pc        = 1'b0;
        mem_read_is_sp        = 1'b0;
        alu_override_imm4     = 1'b0;
        alu_set_flags         = 1'b0;
        set_pc                = 1'b0;
        sr_from_mem           = 1'b0;
        mem_write             = 1'b0;
        set_sp                = 1'b0;
        increase_sp           = 1'b0;
        reset_irq             = 1'b0;
        alu_output_override   = AOO_NONE;
        pc_data_source        = PC_SRC_NEXT_PC;
        mem_write_addr_source = MWA_SP;
        mem_write_data_source = MWD_REGISTER;
        halted                = 1'b0;

        // While reset is held every output keeps its default.
        if (reset) begin
            case (state)
                ST_FETCH: begin
                    if (irq && !in_isr_q) begin
                        next_state = ST_IRQ_PC;
                    end else begin
                        mem_read_is_pc = 1'b1;
                        if (mem_rvalid) begin
                            set_pc         = 1'b1;
                            pc_data_source = PC_SRC_NEXT_PC;
                            next_state     = ST_EXEC;
                        end
                    end
                end

                ST_EXEC: begin
                    next_state = ST_FETCH;
                    case (opcode)
                        OP_ALU_RR: begin
                            reg_write     = 1'b1;
                            alu_set_flags = 1'b1;
                        end
                        OP_ALU_RI: begin
                            reg_write         = 1'b1;
                            alu_set_flags     = 1'b1;
                            alu_override_imm4 = 1'b1;
                        end
                        OP_LDI: begin
                            reg_write           = 1'b1;
                            alu_output_override = AOO_IMM8;
                        end
                        OP_LOAD: begin
                            next_state = ST_LOAD_W;
                        end
                        OP_STORE: begin
                            mem_write             = 1'b1;
                            mem_write_addr_source = MWA_REGISTER;
                            mem_write_data_source = MWD_REGISTER;
                        end
                        OP_PUSH: begin
                            mem_write             = 1'b1;
                            mem_write_addr_source = MWA_SP;
                            mem_write_data_source = MWD_REGISTER;
                            set_sp                = 1'b1;
                        end
                        OP_POP: begin
                            set_sp      = 1'b1;
                            increase_sp = 1'b1;
                            next_state  = ST_POP_R;
                        end
                        OP_HALT: begin
                            next_state = ST_HALT;
                        end
                        OP_BR: begin
                            if (br_taken) begin
                                set_pc         = 1'b1;
                                pc_data_source = PC_SRC_REGISTER;
                            end
                        end
                        OP_CALL: begin
                            mem_write             = 1'b1;
                            mem_write_addr_source = MWA_SP;
                            mem_write_data_source = MWD_THIS_PC;
                            set_sp                = 1'b1;
                            set_pc                = 1'b1;
                            pc_data_source        = PC_SRC_REGISTER;
                        end
                        OP_RET: begin
                            set_sp      = 1'b1;
                            increase_sp = 1'b1;
                            next_state  = ST_RET_R;
                        end
                        OP_RTI: begin
                            set_sp      = 1'b1;
                            increase_sp = 1'b1;
                            next_state  = ST_RTI_SR;
                        end
                        default: begin
                            next_state = ST_FETCH;
                        end
                    endcase
                end

                ST_LOAD_W: begin
                    if (mem_rvalid) begin
                        mem_to_reg = 1'b1;
                        reg_write  = 1'b1;
                        next_state = ST_FETCH;
                    end
                end

                ST_POP_R: begin
                    mem_read_is_sp = 1'b1;
                    if (mem_rvalid) begin
                        mem_to_reg = 1'b1;
                        reg_write  = 1'b1;
                        next_state = ST_FETCH;
                    end
                end

                ST_HALT: begin
                    halted = 1'b1;
                end

                ST_RET_R: begin
                    mem_read_is_sp = 1'b1;
                    if (mem_rvalid) begin
                        set_pc         = 1'b1;
                        pc_data_source = PC_SRC_MEM;
                        next_state     = ST_FETCH;
                    end
                end

                ST_RTI_SR: begin
                    mem_read_is_sp = 1'b1;
                    if (mem_rvalid) begin
                        sr_from_mem = 1'b1;
                        set_sp      = 1'b1;
                        increase_sp = 1'b1;
                        next_state  = ST_RTI_PC;
                    end
                end

                ST_RTI_PC: begin
                    mem_read_is_sp = 1'b1;
                    if (mem_rvalid) begin
                        set_pc         = 1'b1;
                        pc_data_source = PC_SRC_MEM;
                        next_state     = ST_FETCH;
                    end
                end

                ST_IRQ_PC: begin
                    mem_write             = 1'b1;
                    mem_write_addr_source = MWA_SP;
                    mem_write_data_source = MWD_THIS_PC;
                    set_sp                = 1'b1;
                    next_state            = ST_IRQ_SR;
                end

                ST_IRQ_SR: begin
                    mem_write             = 1'b1;
                    mem_write_addr_source = MWA_SP;
                    mem_write_data_source = MWD_SR;
                    set_sp                = 1'b1;
                    next_state            = ST_IRQ_JMP;
                end

                ST_IRQ_JMP: begin
                    set_pc         = 1'b1;
                    pc_data_source = PC_SRC_IRQ;
                    reset_irq      = 1'b1;
                    next_state     = ST_FETCH;
                end

                default: begin
                    next_state = ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control.sv
module tb_cpu_control;
    import cpu_control_pkg::*;

    logic                   clock;
    logic                   reset;
    logic [15:0]            current_instruction;
    logic                   Z_in;
    logic                   N_in;
    logic                   irq;
    logic                   mem_rvalid;
    logic                   reg_write;
    logic                   mem_to_reg;
    logic                   mem_read_is_pc;
    logic                   mem_read_is_sp;
    logic                   alu_override_imm4;
    logic                   alu_set_flags;
    logic                   set_pc;
    logic                   sr_from_mem;
    logic                   mem_write;
    logic                   set_sp;
    logic                   increase_sp;
    logic                   reset_irq;
    alu_output_override_t   alu_output_override;
    pc_data_source_t        pc_data_source;
    mem_write_addr_source_t mem_write_addr_source;
    mem_write_data_source_t mem_write_data_source;
    logic                   halted;
    logic                   in_isr;

    int tests_run;
    int tests_failed;

    cpu_control dut (
        .clock                 (clock),
        .reset                 (reset),
        .current_instruction   (current_instruction),
        .Z_in                  (Z_in),
        .N_in                  (N_in),
        .irq                   (irq),
        .mem_rvalid            (mem_rvalid),
        .reg_write             (reg_write),
        .mem_to_reg            (mem_to_reg),
        .mem_read_is_pc        (mem_read_is_pc),
        .mem_read_is_sp        (mem_read_is_sp),
        .alu_override_imm4     (alu_override_imm4),
        .alu_set_flags         (alu_set_flags),
        .set_pc                (set_pc),
        .sr_from_mem           (sr_from_mem),
        .mem_write             (mem_write),
        .set_sp                (set_sp),
        .increase_sp           (increase_sp),
        .reset_irq             (reset_irq),
        .alu_output_override   (alu_output_override),
        .pc_data_source        (pc_data_source),
        .mem_write_addr_source (mem_write_addr_source),
        .mem_write_data_source (mem_write_data_source),
        .halted                (halted),
        .in_isr                (in_isr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Strobe bit positions in the packed comparison word.
    localparam logic [11:0] S_RW   = 12'h800;
    localparam logic [11:0] S_M2R  = 12'h400;
    localparam logic [11:0] S_RPC  = 12'h200;
    localparam logic [11:0] S_RSP  = 12'h100;
    localparam logic [11:0] S_IMM4 = 12'h080;
    localparam logic [11:0] S_FLG  = 12'h040;
    localparam logic [11:0] S_SPC  = 12'h020;
    localparam logic [11:0] S_SRM  = 12'h010;
    localparam logic [11:0] S_MW   = 12'h008;
    localparam logic [11:0] S_SSP  = 12'h004;
    localparam logic [11:0] S_INC  = 12'h002;
    localparam logic [11:0] S_RIRQ = 12'h001;
    localparam logic [11:0] S_NONE = 12'h000;

    typedef struct {
        logic [15:0]            instr;
        logic                   z;
        logic                   n;
        logic [11:0]            strb;
        pc_data_source_t        pc_src;
        mem_write_addr_source_t wa;
        mem_write_data_source_t wd;
        alu_output_override_t   aoo;
    } vec_t;

    vec_t vecs [16];

    // Selects are compared only where the matching strobe makes them matter,
    // or everywhere when all_enums is set (reset).
    task automatic chk(input string name, input logic [11:0] es, input logic eh, input logic ei,
                       input pc_data_source_t ep, input mem_write_addr_source_t ewa,
                       input mem_write_data_source_t ewd, input alu_output_override_t ea,
                       input bit all_enums);
        logic [11:0] as;
        bit bad;
        as = {reg_write, mem_to_reg, mem_read_is_pc, mem_read_is_sp, alu_override_imm4,
              alu_set_flags, set_pc, sr_from_mem, mem_write, set_sp, increase_sp, reset_irq};
        bad = (as !== es) || (halted !== eh) || (in_isr !== ei);
        if ((all_enums || (es & S_SPC) != 0) && pc_data_source !== ep) bad = 1'b1;
        if ((all_enums || (es & S_MW) != 0) && mem_write_addr_source !== ewa) bad = 1'b1;
        if ((all_enums || (es & S_MW) != 0) && mem_write_data_source !== ewd) bad = 1'b1;
        if ((all_enums || (es & S_RW) != 0) && alu_output_override !== ea) bad = 1'b1;
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL %s: got strb=%03h halted=%0b in_isr=%0b pc_src=%0d wa=%0d wd=%0d aoo=%0d; want strb=%03h halted=%0b in_isr=%0b pc_src=%0d wa=%0d wd=%0d aoo=%0d",
                     name, as, halted, in_isr, pc_data_source, mem_write_addr_source,
                     mem_write_data_source, alu_output_override,
                     es, eh, ei, ep, ewa, ewd, ea);
        end
    endtask

    task automatic chk_s(input string name, input logic [11:0] es, input logic eh, input logic ei,
                         input pc_data_source_t ep);
        chk(name, es, eh, ei, ep, MWA_SP, MWD_REGISTER, AOO_NONE, 1'b0);
    endtask

    task automatic chk_w(input string name, input logic [11:0] es, input logic ei,
                         input mem_write_data_source_t ewd);
        chk(name, es, 1'b0, ei, PC_SRC_NEXT_PC, MWA_SP, ewd, AOO_NONE, 1'b0);
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic set_in(input logic [15:0] instr, input logic z, input logic n,
                          input logic rv, input logic rq);
        current_instruction = instr;
        Z_in                = z;
        N_in                = n;
        mem_rvalid          = rv;
        irq                 = rq;
        #1;
    endtask

    // Returns at a negedge with reset released and the FSM in FETCH.
    task automatic do_reset();
        tick();
        reset = 1'b0;
        irq   = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        vecs[0]  = '{16'h0000, 1'b0, 1'b0, S_NONE,               PC_SRC_NEXT_PC,  MWA_SP,       MWD_REGISTER, AOO_NONE};
        vecs[1]  = '{16'h1123, 1'b0, 1'b0, S_RW|S_FLG,           PC_SRC_NEXT_PC,  MWA_SP,       MWD_REGISTER, AOO_NONE};
        vecs[2]  = '{16'h2456, 1'b0, 1'b0, S_RW|S_FLG|S_IMM4,    PC_SRC_NEXT_PC,  MWA_SP,       MWD_REGISTER, AOO_NONE};
        vecs[3]  = '{16'h3AB7, 1'b0, 1'b0, S_RW,                 PC_SRC_NEXT_PC,  MWA_SP,       MWD_REGISTER, AOO_IMM8};
        vecs[4]  = '{16'h5120, 1'b0, 1'b0, S_MW,                 PC_SRC_NEXT_PC,  MWA_REGISTER, MWD_REGISTER, AOO_NONE};
        vecs[5]  = '{16'h6100, 1'b0, 1'b0, S_MW|S_SSP,           PC_SRC_NEXT_PC,  MWA_SP,       MWD_REGISTER, AOO_NONE};
        vecs[6]  = '{16'h9102, 1'b1, 1'b0, S_NONE,               PC_SRC_NEXT_PC,  MWA_SP,       MWD_REGISTER, AOO_NONE};
        vecs[7]  = '{16'h9102, 1'b0, 1'b0, S_SPC,                PC_SRC_REGISTER, MWA_SP,       MWD_REGISTER, AOO_NONE};
        vecs[8]  = '{16'h9000, 1'b0, 1'b0, S_SPC,                PC_SRC_REGISTER, MWA_SP,       MWD_REGISTER, AOO_NONE};
        vecs[9]  = '{16'h9001, 1'b0, 1'b1, S_NONE,               PC_SRC_NEXT_PC,  MWA_SP,       MWD_REGISTER, AOO_NONE};
        vecs[10] = '{16'h9003, 1'b0, 1'b1, S_SPC,                PC_SRC_REGISTER, MWA_SP,       MWD_REGISTER, AOO_NONE};
        vecs[11] = '{16'h9004, 1'b1, 1'b1, S_NONE,               PC_SRC_NEXT_PC,  MWA_SP,       MWD_REGISTER, AOO_NONE};
        vecs[12] = '{16'h9005, 1'b1, 1'b1, S_NONE,               PC_SRC_NEXT_PC,  MWA_SP,       MWD_REGISTER, AOO_NONE};
        vecs[13] = '{16'hA200, 1'b0, 1'b0, S_MW|S_SSP|S_SPC,     PC_SRC_REGISTER, MWA_SP,       MWD_THIS_PC,  AOO_NONE};
        vecs[14] = '{16'hD000, 1'b0, 1'b0, S_NONE,               PC_SRC_NEXT_PC,  MWA_SP,       MWD_REGISTER, AOO_NONE};
        vecs[15] = '{16'hF000, 1'b0, 1'b0, S_NONE,               PC_SRC_NEXT_PC,  MWA_SP,       MWD_REGISTER, AOO_NONE};

        reset               = 1'b0;
        current_instruction = 16'h0000;
        Z_in                = 1'b0;
        N_in                = 1'b0;
        irq                 = 1'b1;
        mem_rvalid          = 1'b1;

        // Reset held: everything forced off even with rvalid/irq asserted.
        tick();
        set_in(16'hA200, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("reset_forced", S_NONE, 1'b0, 1'b0, PC_SRC_NEXT_PC, MWA_SP, MWD_REGISTER, AOO_NONE, 1'b1);
        tick();
        reset = 1'b1;
        set_in(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("first_fetch", S_RPC|S_SPC, 1'b0, 1'b0, PC_SRC_NEXT_PC, MWA_SP, MWD_REGISTER, AOO_NONE, 1'b1);

        // Fetch stalled three cycles on mem_rvalid.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
            chk_s($sformatf("fetch_wait%0d", i), S_RPC, 1'b0, 1'b0, PC_SRC_NEXT_PC);
            tick();
        end
        set_in(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_s("fetch_done", S_RPC|S_SPC, 1'b0, 1'b0, PC_SRC_NEXT_PC);
        tick();
        set_in(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_s("fetch_wait_exec", S_NONE, 1'b0, 1'b0, PC_SRC_NEXT_PC);

        // Single-cycle EXEC opcodes from the table.
        for (int v = 0; v < 16; v++) begin
            do_reset();
            set_in(vecs[v].instr, vecs[v].z, vecs[v].n, 1'b1, 1'b0);
            chk_s($sformatf("v%0d_fetch", v), S_RPC|S_SPC, 1'b0, 1'b0, PC_SRC_NEXT_PC);
            tick();
            set_in(vecs[v].instr, vecs[v].z, vecs[v].n, 1'b1, 1'b0);
            chk($sformatf("v%0d_exec_%04h", v, vecs[v].instr), vecs[v].strb, 1'b0, 1'b0,
                vecs[v].pc_src, vecs[v].wa, vecs[v].wd, vecs[v].aoo, 1'b0);
            tick();
            set_in(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
            chk_s($sformatf("v%0d_return", v), S_RPC, 1'b0, 1'b0, PC_SRC_NEXT_PC);
        end

        // POP: EXEC increments SP, POP_R waits for data.
        do_reset();
        set_in(16'h7300, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(16'h7300, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_s("pop_exec", S_SSP|S_INC, 1'b0, 1'b0, PC_SRC_NEXT_PC);
        tick();
        set_in(16'h7300, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_s("pop_r_wait", S_RSP, 1'b0, 1'b0, PC_SRC_NEXT_PC);
        tick();
        set_in(16'h7300, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_s("pop_r_data", S_RSP|S_M2R|S_RW, 1'b0, 1'b0, PC_SRC_NEXT_PC);
        tick();
        set_in(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_s("pop_return", S_RPC, 1'b0, 1'b0, PC_SRC_NEXT_PC);

        // LOAD: nothing in EXEC, register write once data is valid.
        do_reset();
        set_in(16'h4100, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(16'h4100, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_s("load_exec", S_NONE, 1'b0, 1'b0, PC_SRC_NEXT_PC);
        tick();
        set_in(16'h4100, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_s("load_w_wait", S_NONE, 1'b0, 1'b0, PC_SRC_NEXT_PC);
        tick();
        set_in(16'h4100, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_s("load_w_data", S_M2R|S_RW, 1'b0, 1'b0, PC_SRC_NEXT_PC);
        tick();
        set_in(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_s("load_return", S_RPC, 1'b0, 1'b0, PC_SRC_NEXT_PC);

        // RET: PC reloaded from the stack.
        do_reset();
        set_in(16'hB000, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(16'hB000, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_s("ret_exec", S_SSP|S_INC, 1'b0, 1'b0, PC_SRC_NEXT_PC);
        tick();
        set_in(16'hB000, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_s("ret_r", S_RSP|S_SPC, 1'b0, 1'b0, PC_SRC_MEM);
        tick();
        set_in(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_s("ret_return", S_RPC, 1'b0, 1'b0, PC_SRC_NEXT_PC);

        // Interrupt entry, masked second irq, RTI, then irq taken again.
        do_reset();
        set_in(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_s("irq_fetch", S_NONE, 1'b0, 1'b0, PC_SRC_NEXT_PC);
        tick();
        set_in(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_w("irq_pc", S_MW|S_SSP, 1'b0, MWD_THIS_PC);
        tick();
        set_in(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_w("irq_sr", S_MW|S_SSP, 1'b0, MWD_SR);
        tick();
        set_in(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_s("irq_jmp", S_SPC|S_RIRQ, 1'b0, 1'b1, PC_SRC_IRQ);
        tick();
        set_in(16'hC000, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_s("isr_fetch_masked", S_RPC|S_SPC, 1'b0, 1'b1, PC_SRC_NEXT_PC);
        tick();
        set_in(16'hC000, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_s("rti_exec", S_SSP|S_INC, 1'b0, 1'b1, PC_SRC_NEXT_PC);
        tick();
        set_in(16'hC000, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_s("rti_sr_wait", S_RSP, 1'b0, 1'b1, PC_SRC_NEXT_PC);
        tick();
        set_in(16'hC000, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_s("rti_sr_data", S_RSP|S_SRM|S_SSP|S_INC, 1'b0, 1'b1, PC_SRC_NEXT_PC);
        tick();
        set_in(16'hC000, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_s("rti_pc", S_RSP|S_SPC, 1'b0, 1'b1, PC_SRC_MEM);
        tick();
        set_in(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_s("post_rti_irq_fetch", S_NONE, 1'b0, 1'b0, PC_SRC_NEXT_PC);
        tick();
        set_in(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_w("post_rti_irq_pc", S_MW|S_SSP, 1'b0, MWD_THIS_PC);

        // HALT absorbs irq; one reset edge returns to FETCH.
        do_reset();
        set_in(16'h8000, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(16'h8000, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_s("halt_exec", S_NONE, 1'b0, 1'b0, PC_SRC_NEXT_PC);
        for (int i = 0; i < 3; i++) begin
            tick();
            set_in(16'h8000, 1'b0, 1'b0, 1'b1, 1'b1);
            chk_s($sformatf("halt_irq%0d", i), S_NONE, 1'b1, 1'b0, PC_SRC_NEXT_PC);
        end
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        set_in(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_s("halt_reset_fetch", S_RPC|S_SPC, 1'b0, 1'b0, PC_SRC_NEXT_PC);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
